nios_dbg_cmd_sync: RTL
======================

// Module: nios_dbg_cmd_sync
// PURPOSE
//  System-clock half of the Nios II JTAG debug slave, generalised in SR width, IR width and sync depth.
//  Brings update-DR/update-IR strobes from the virtual-JTAG (TCK) domain into clk.
//  On update-DR, captures the TCK-domain shift register into jdo and issues one-hot
//  take_action / take_no_action strobes per instruction. Adds overrun detection, a command counter and optional ack handshake.
// PARAMETERS
//  SR_W        38  width of sr / jdo
//  IR_W        2   width of ir_in; NUM_CMD = 2**IR_W strobe channels
//  ACTION_BIT  34  sr bit selecting action (1) vs no-action (0); must be < SR_W
//  SYNC_STAGES 2   synchroniser depth for vs_udr / vs_uir; must be >= 2
//  CNT_W       8   width of cmd_cnt
// PORTS
//  clk            in   1        system clock
//  reset_n        in   1        asynchronous active-low reset
//  vs_udr         in   1        virtual update-DR level, TCK domain (async to clk)
//  vs_uir         in   1        virtual update-IR level, TCK domain (async to clk)
//  ir_in          in   IR_W     instruction register; stable while vs_uir is high
//  sr             in   SR_W     TCK-domain shift register; stable while vs_udr is high
//  overrun_clr    in   1        clears overrun
//  cmd_ack        in   1        command consumed (only with DBG_CMD_ACK_EN)
//  jdo            out  SR_W     captured data
//  take_action    out  NUM_CMD  one-hot action strobe, indexed by latched IR
//  take_no_action out  NUM_CMD  one-hot no-action strobe, indexed by latched IR
//  busy           out  1        FSM not in IDLE
//  overrun        out  1        sticky: update-DR arrived while busy
//  cmd_cnt        out  CNT_W    accepted-command counter, wraps
// BEHAVIOUR
//  Reset: jdo=0, take_*=0, busy=0, overrun=0, cmd_cnt=0, ir_q=0, sync chains=0, armed=0, FSM=IDLE.
//  Sync: each strobe passes through SYNC_STAGES flops, then an edge-detect flop.
//  - Rising edge = last stage 1 and edge flop 0.
//  armed: set once synchronised vs_udr is seen 0. udr edges are ignored while armed=0.
//  - A vs_udr held high through reset release produces no command.
//  uir edge: ir_q <= ir_in at that edge (any FSM state).
//  FSM states: IDLE, PULSE, WAIT_ACK.
//  - IDLE + armed udr edge: jdo <= sr; a = sr[ACTION_BIT]; take_action[ir_q] <= a; take_no_action[ir_q] <= !a; cmd_cnt++; -> PULSE.
//  - PULSE: without macro, clear take_* and go to IDLE (strobe is exactly 1 cycle).
//  - PULSE: with macro, go to WAIT_ACK with take_* held.
//  - WAIT_ACK: on cmd_ack, clear take_* and go to IDLE. cmd_ack high in PULSE is also honoured: clear and go to IDLE.
//  Latency: vs_udr first sampled high at edge N -> jdo / take_* / cmd_cnt update at edge N+SYNC_STAGES.
//  Simultaneous udr and uir edges: the command uses the old ir_q; ir_q then updates.
//  udr edge while busy: command dropped, jdo unchanged, cmd_cnt unchanged, overrun <= 1.
//  overrun_clr together with a new overrun: set wins.
//  cmd_cnt wraps from 2**CNT_W-1 to 0; no saturation.
//  Exactly one bit of take_action|take_no_action is high while busy; all bits are 0 in IDLE.
//  jdo holds its value until the next accepted command.
//  Reset mid-command: all outputs return to reset values asynchronously.
//  - The next command requires armed again, i.e. vs_udr seen low after reset.
// CONFIGURATION
//  DBG_CMD_ACK_EN defined: cmd_ack port present; WAIT_ACK used; strobes are levels until acked.
//  - busy covers PULSE and WAIT_ACK.
//  DBG_CMD_ACK_EN undefined: cmd_ack port absent; WAIT_ACK unreachable.
//  - Strobes are 1-cycle pulses; busy is high for exactly 1 cycle per command.
// TESTING
//  T1 defaults, no macro: ir_in=2 with uir pulse, then sr[34]=1, sr=38'h4_0000_00AB with vs_udr held 4 clk
//     -> at edge N+2: jdo=38'h4_0000_00AB, take_action=4'b0100 for 1 cycle, cmd_cnt=1.
//  T2 same with sr[34]=0 and ir_in=1 -> take_no_action=4'b0010 for 1 cycle, take_action=0.
//  T3 vs_udr high while reset_n released -> no strobe, cmd_cnt=0.
//     - then drop vs_udr and raise it again -> one command.
//  T4 macro on: command issued, cmd_ack withheld 10 cycles -> strobe and busy high 10+ cycles.
//     - second udr during the hold -> overrun=1, cmd_cnt unchanged; overrun_clr -> 0.
//  T5 CNT_W=2: five commands -> cmd_cnt sequence 1,2,3,0,1.
//     - uir and udr edges in the same cycle -> strobe index = old IR.

Source files
------------

// File: rtl/nios_dbg_cmd_sync.sv
// System-clock side of the Nios II JTAG debug slave: synchronises update-DR/IR strobes from TCK and issues command strobes.
// Optional macro DBG_CMD_ACK_EN: strobes hold as levels until cmd_ack instead of pulsing for one cycle.
module nios_dbg_cmd_sync #(
  parameter int SR_W        = 38,
  parameter int IR_W        = 2,
  parameter int ACTION_BIT  = 34,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   vs_udr,
  input  logic                   vs_uir,
  input  logic [IR_W-1:0]        ir_in,
  input  logic [SR_W-1:0]        sr,
  input  logic                   overrun_clr,
`ifdef DBG_CMD_ACK_EN
  input  logic                   cmd_ack,
`endif
  output logic [SR_W-1:0]        jdo,
  output logic [(2**IR_W)-1:0]   take_action,
  output logic [(2**IR_W)-1:0]   take_no_action,
  output logic                   busy,
  output logic                   overrun,
  output logic [CNT_W-1:0]       cmd_cnt,
  output logic [1:0]             dbg_state_o
);

  localparam int NUM_CMD = 2**IR_W;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PULSE    = 2'd1,
    ST_WAIT_ACK = 2'd2
  } state_t;

  state_t                 state_q;
  logic [SYNC_STAGES-1:0] udr_sync_q;
  logic [SYNC_STAGES-1:0] uir_sync_q;
  logic [SYNC_STAGES-1:0] fill_q;
  logic                   udr_edge_q;
  logic                   uir_edge_q;
  logic                   armed_q;
  logic [IR_W-1:0]        ir_q;
  logic [SR_W-1:0]        jdo_q;
  logic [NUM_CMD-1:0]     act_q;
  logic [NUM_CMD-1:0]     noact_q;
  logic                   busy_q;
  logic                   overrun_q;
  logic [CNT_W-1:0]       cnt_q;

  logic                   udr_rise;
  logic                   uir_rise;
  logic [NUM_CMD-1:0]     ir_onehot;

  // Handshake: a command is offered by the strobes while busy; with the ack
  // option it is consumed on any cycle where cmd_ack is high in PULSE/WAIT_ACK.
  assign udr_rise  = armed_q & udr_sync_q[SYNC_STAGES-1] & ~udr_edge_q;
  assign uir_rise  = uir_sync_q[SYNC_STAGES-1] & ~uir_edge_q;
  assign ir_onehot = NUM_CMD'(1) << ir_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      udr_sync_q <= '0;
      uir_sync_q <= '0;
      fill_q     <= '0;
      udr_edge_q <= 1'b0;
      uir_edge_q <= 1'b0;
      armed_q    <= 1'b0;
      ir_q       <= '0;
      jdo_q      <= '0;
      act_q      <= '0;
      noact_q    <= '0;
      busy_q     <= 1'b0;
      overrun_q  <= 1'b0;
      cnt_q      <= '0;
    end else begin
      udr_sync_q <= {udr_sync_q[SYNC_STAGES-2:0], vs_udr};
      uir_sync_q <= {uir_sync_q[SYNC_STAGES-2:0], vs_uir};
      udr_edge_q <= udr_sync_q[SYNC_STAGES-1];
      uir_edge_q <= uir_sync_q[SYNC_STAGES-1];
      // fill_q marks when the chain holds real samples rather than reset zeros,
      // so a vs_udr held high through reset never looks like it was low.
      fill_q     <= {fill_q[SYNC_STAGES-2:0], 1'b1};
      if (fill_q[SYNC_STAGES-1] && !udr_sync_q[SYNC_STAGES-1])
        armed_q <= 1'b1;

      if (uir_rise)
        ir_q <= ir_in;

      if (udr_rise && (state_q != ST_IDLE))
        overrun_q <= 1'b1;
      else if (overrun_clr)
        overrun_q <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          if (udr_rise) begin
            jdo_q   <= sr;
            act_q   <= sr[ACTION_BIT] ? ir_onehot : '0;
            noact_q <= sr[ACTION_BIT] ? '0 : ir_onehot;
            cnt_q   <= cnt_q + CNT_W'(1);
            busy_q  <= 1'b1;
            state_q <= ST_PULSE;
          end
        end
        ST_PULSE: begin
`ifdef DBG_CMD_ACK_EN
          if (cmd_ack) begin
            act_q   <= '0;
            noact_q <= '0;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else begin
            state_q <= ST_WAIT_ACK;
          end
`else
          act_q   <= '0;
          noact_q <= '0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
`endif
        end
        ST_WAIT_ACK: begin
`ifdef DBG_CMD_ACK_EN
          if (cmd_ack) begin
            act_q   <= '0;
            noact_q <= '0;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
`else
          act_q   <= '0;
          noact_q <= '0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
`endif
        end
        default: begin
          act_q   <= '0;
          noact_q <= '0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign jdo            = jdo_q;
  assign take_action    = act_q;
  assign take_no_action = noact_q;
  assign busy           = busy_q;
  assign overrun        = overrun_q;
  assign cmd_cnt        = cnt_q;
  assign dbg_state_o    = state_q;

endmodule
